// File: rtl/mem_wait_ctrl_pkg.sv
// Shared types and constants for the memory wait-state / startup-test controller.
package mem_wait_ctrl_pkg;

    typedef enum logic [3:0] {
        T_WRITE,
        T_SETTLE,
        T_READ,
        T_WAIT,
        T_CHECK,
        FAIL,
        IDLE,
        RD_WAIT,
        RELEASE
    } mem_wait_state_t;

    localparam logic [31:0] TEST_PATTERN_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/lat_max_sel.sv
// Combinational maximum of the per-channel latency fields selected by a mask.
module lat_max_sel #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned LAT_W = 3
) (
    input  logic [N_CH-1:0]       mask_i,
    input  logic [N_CH*LAT_W-1:0] lat_i,
    output logic [LAT_W-1:0]      max_o
);

    always_comb begin
        max_o = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (mask_i[i] && (lat_i[i*LAT_W +: LAT_W] > max_o)) begin
                max_o = lat_i[i*LAT_W +: LAT_W];
            end
        end
    end

endmodule

// File: rtl/mem_wait_ctrl.sv
// Memory controller: power-up write/read-back self-test per channel, then runtime read
// wait-state insertion with per-channel chip-select masking.
module mem_wait_ctrl
    import mem_wait_ctrl_pkg::*;
#(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned LAT_W        = 3,
    parameter int unsigned SETTLE_CYC   = 13,
    parameter logic [31:0] TEST_PATTERN = TEST_PATTERN_DEF,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_CH-1:0]        req_rd_i,
    input  logic [N_CH*LAT_W-1:0]  lat_cfg_i,
    input  logic [N_CH*32-1:0]     test_rdata_i,
    output logic                   stall_n_o,
    output logic [N_CH-1:0]        force_csb_o,
    output logic                   test_en_o,
    output logic [N_CH-1:0]        test_cs_o,
    output logic                   test_we_o,
    output logic [31:0]            test_wdata_o,
    output logic                   init_done_o,
    output logic                   test_fail_o,
    output logic [$clog2(N_CH):0]  fail_ch_o
);

    localparam int unsigned ChW    = $clog2(N_CH) + 1;
    localparam int unsigned IdxW   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned RetryW = $clog2(MAX_RETRY) + 1;

    mem_wait_state_t   state_q, state_d;
    logic [ChW-1:0]    ch_q, ch_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [LAT_W-1:0]  wmax_q, wmax_d;

    logic [LAT_W-1:0]  lat_arr   [N_CH];
    logic [31:0]       rdata_arr [N_CH];
    logic [IdxW-1:0]   ch_idx;
    logic [LAT_W-1:0]  lat_sel;
    logic [31:0]       rdata_sel;
    logic [LAT_W-1:0]  req_wmax;
    logic [N_CH-1:0]   cs_onehot;

    for (genvar g = 0; g < N_CH; g++) begin : g_split
        assign lat_arr[g]   = lat_cfg_i[g*LAT_W +: LAT_W];
        assign rdata_arr[g] = test_rdata_i[g*32 +: 32];
    end

    assign ch_idx    = ch_q[IdxW-1:0];
    assign lat_sel   = lat_arr[ch_idx];
    assign rdata_sel = rdata_arr[ch_idx];
    assign cs_onehot = N_CH'(1) << ch_idx;

    lat_max_sel #(
        .N_CH  (N_CH),
        .LAT_W (LAT_W)
    ) u_lat_max_sel (
        .mask_i (req_rd_i),
        .lat_i  (lat_cfg_i),
        .max_o  (req_wmax)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= T_WRITE;
            ch_q    <= '0;
            retry_q <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            wmax_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            wmax_q  <= wmax_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        wmax_d  = wmax_q;
        unique case (state_q)
            T_WRITE: begin
                state_d = T_SETTLE;
                cnt_d   = '0;
            end
            T_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = T_READ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            T_READ: begin
                // A zero latency field skips the wait state entirely.
                state_d = (lat_sel == '0) ? T_CHECK : T_WAIT;
                cnt_d   = '0;
            end
            T_WAIT: begin
                if (cnt_q == (CNT_W'(lat_sel) - CNT_W'(1))) begin
                    state_d = T_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            T_CHECK: begin
                if (rdata_sel == TEST_PATTERN) begin
                    if (ch_q == ChW'(N_CH - 1)) begin
                        state_d = IDLE;
                    end else begin
                        ch_d    = ch_q + ChW'(1);
                        retry_d = '0;
                        state_d = T_WRITE;
                    end
                end else if (retry_q == RetryW'(MAX_RETRY - 1)) begin
                    state_d = FAIL;
                end else begin
                    retry_d = retry_q + RetryW'(1);
                    state_d = T_WRITE;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            IDLE: begin
                if ((req_rd_i != '0) && (req_wmax != '0)) begin
                    state_d = RD_WAIT;
                    mask_d  = req_rd_i;
                    wmax_d  = req_wmax;
                    cnt_d   = '0;
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == (CNT_W'(wmax_q) - CNT_W'(1))) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                cnt_d   = '0;
                mask_d  = '0;
                wmax_d  = '0;
            end
            default: begin
                state_d = T_WRITE;
            end
        endcase
    end

    // Outputs decode registered state only, so there is no input-to-output path.
    always_comb begin
        stall_n_o   = 1'b0;
        force_csb_o = '0;
        test_en_o   = 1'b1;
        test_cs_o   = '0;
        test_we_o   = 1'b0;
        init_done_o = 1'b0;
        test_fail_o = 1'b0;
        fail_ch_o   = '0;
        unique case (state_q)
            T_WRITE: begin
                test_cs_o = cs_onehot;
                test_we_o = 1'b1;
            end
            T_READ, T_WAIT: begin
                test_cs_o = cs_onehot;
            end
            FAIL: begin
                test_fail_o = 1'b1;
                fail_ch_o   = ch_q;
            end
            IDLE: begin
                test_en_o   = 1'b0;
                stall_n_o   = 1'b1;
                init_done_o = 1'b1;
            end
            RD_WAIT: begin
                test_en_o   = 1'b0;
                init_done_o = 1'b1;
                // First wait cycle lets the original access reach the macro.
                force_csb_o = (cnt_q != '0) ? mask_q : '0;
            end
            RELEASE: begin
                test_en_o   = 1'b0;
                stall_n_o   = 1'b1;
                init_done_o = 1'b1;
                force_csb_o = mask_q;
            end
            default: begin
                test_cs_o = '0;
            end
        endcase
    end

    assign test_wdata_o = TEST_PATTERN;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Directed bench for mem_wait_ctrl: startup pass/fail, runtime stalls, reset abort.
module tb_mem_wait_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  req_rd = '0;
    logic [5:0]  lat_cfg = '0;
    logic [63:0] test_rdata = '0;
    logic        stall_n;
    logic [1:0]  force_csb;
    logic        test_en;
    logic [1:0]  test_cs;
    logic        test_we;
    logic [31:0] test_wdata;
    logic        init_done;
    logic        test_fail;
    logic [1:0]  fail_ch;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_wait_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_rd_i     (req_rd),
        .lat_cfg_i    (lat_cfg),
        .test_rdata_i (test_rdata),
        .stall_n_o    (stall_n),
        .force_csb_o  (force_csb),
        .test_en_o    (test_en),
        .test_cs_o    (test_cs),
        .test_we_o    (test_we),
        .test_wdata_o (test_wdata),
        .init_done_o  (init_done),
        .test_fail_o  (test_fail),
        .fail_ch_o    (fail_ch)
    );

    // Leaves the DUT in T_WRITE on channel 0, sampled at a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic bring_up(input int exp_edges);
        int edges;
        do_reset();
        edges = 0;
        while (init_done !== 1'b1 && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        n_checks++;
        if (edges != exp_edges) begin
            n_fail++;
            $display("FAIL bring_up_edges: got %0d expected %0d", edges, exp_edges);
        end
    endtask

    task automatic test_reset();
        lat_cfg    = {3'd2, 3'd1};
        test_rdata = {2{32'hFFFF_FFFF}};
        do_reset();
        n_checks++;
        if ({stall_n, test_en, force_csb, init_done, test_fail, fail_ch} !== 8'b0100_0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall_n=%b test_en=%b force_csb=%b init=%b fail=%b ch=%0d",
                     stall_n, test_en, force_csb, init_done, test_fail, fail_ch);
        end
        n_checks++;
        if (test_cs !== 2'b01 || test_we !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_write: got cs=%b we=%b expected cs=01 we=1", test_cs, test_we);
        end
        n_checks++;
        if (test_wdata !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL wdata: got %h expected ffffffff", test_wdata);
        end
    endtask

    task automatic test_startup_pass();
        int edges, cs0, cs1, wr1, first1;
        lat_cfg    = {3'd2, 3'd1};
        test_rdata = {2{32'hFFFF_FFFF}};
        do_reset();
        edges = 0; cs0 = 0; cs1 = 0; wr1 = 0; first1 = -1;
        while (init_done !== 1'b1 && edges < 200) begin
            if (test_cs == 2'b01) cs0++;
            if (test_cs == 2'b10) begin
                cs1++;
                if (test_we) wr1++;
                if (first1 < 0) first1 = edges;
            end
            @(negedge clk);
            edges++;
        end
        n_checks++;
        if (edges != 35) begin
            n_fail++;
            $display("FAIL pass_init_edges: got %0d expected 35", edges);
        end
        n_checks++;
        if (cs0 != 3 || cs1 != 4) begin
            n_fail++;
            $display("FAIL pass_cs_cycles: got ch0=%0d ch1=%0d expected 3 4", cs0, cs1);
        end
        n_checks++;
        if (first1 != 17 || wr1 != 1) begin
            n_fail++;
            $display("FAIL pass_ch1_start: got first=%0d writes=%0d expected 17 1", first1, wr1);
        end
        n_checks++;
        if (stall_n !== 1'b1 || test_en !== 1'b0 || test_cs !== 2'b00 || test_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_idle: got stall_n=%b test_en=%b cs=%b fail=%b expected 1 0 00 0",
                     stall_n, test_en, test_cs, test_fail);
        end
    endtask

    task automatic test_startup_fail();
        int edges, wr1;
        lat_cfg    = {3'd2, 3'd1};
        test_rdata = {32'h0000_0000, 32'hFFFF_FFFF};
        do_reset();
        edges = 0; wr1 = 0;
        while (test_fail !== 1'b1 && edges < 300) begin
            if (test_cs == 2'b10 && test_we) wr1++;
            @(negedge clk);
            edges++;
        end
        n_checks++;
        if (edges != 71 || wr1 != 3) begin
            n_fail++;
            $display("FAIL fail_timing: got edges=%0d writes=%0d expected 71 3", edges, wr1);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (test_fail !== 1'b1 || fail_ch !== 2'd1 || stall_n !== 1'b0 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fail_sticky: got fail=%b ch=%0d stall_n=%b init=%b expected 1 1 0 0",
                     test_fail, fail_ch, stall_n, init_done);
        end
        n_checks++;
        if (test_en !== 1'b1 || test_cs !== 2'b00) begin
            n_fail++;
            $display("FAIL fail_ports: got test_en=%b cs=%b expected 1 00", test_en, test_cs);
        end
        test_rdata = {2{32'hFFFF_FFFF}};
    endtask

    task automatic test_single_read();
        logic [5:0] exp_stall = 6'b111000;
        logic [5:0] exp_force = 6'b001110;
        lat_cfg    = {3'd2, 3'd3};
        test_rdata = {2{32'hFFFF_FFFF}};
        bring_up(37);
        @(negedge clk);
        req_rd = 2'b01;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (stall_n !== exp_stall[c-1] || force_csb !== {1'b0, exp_force[c-1]}) begin
                n_fail++;
                $display("FAIL single_c%0d: got stall_n=%b force_csb=%b expected %b 0%b",
                         c, stall_n, force_csb, exp_stall[c-1], exp_force[c-1]);
            end
            if (c == 5) req_rd = 2'b00;
        end
    endtask

    task automatic test_multi_read();
        logic [6:0] exp_stall = 7'b111_0000;
        logic [6:0] exp_force = 7'b001_1110;
        lat_cfg = {3'd4, 3'd1};
        @(negedge clk);
        req_rd = 2'b11;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            n_checks++;
            if (stall_n !== exp_stall[c-1] || force_csb !== {2{exp_force[c-1]}}) begin
                n_fail++;
                $display("FAIL multi_c%0d: got stall_n=%b force_csb=%b expected %b %b%b",
                         c, stall_n, force_csb, exp_stall[c-1], exp_force[c-1], exp_force[c-1]);
            end
            if (c == 6) req_rd = 2'b00;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_stall = 4'b1110;
        logic [3:0] exp_force = 4'b0010;
        @(negedge clk);
        req_rd = 2'b01;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (stall_n !== exp_stall[c-1] || force_csb !== {1'b0, exp_force[c-1]}) begin
                n_fail++;
                $display("FAIL b2b_c%0d: got stall_n=%b force_csb=%b expected %b 0%b",
                         c, stall_n, force_csb, exp_stall[c-1], exp_force[c-1]);
            end
            if (c == 3) req_rd = 2'b00;
        end
    endtask

    task automatic test_zero_lat();
        lat_cfg = {3'd0, 3'd0};
        bring_up(32);
        @(negedge clk);
        req_rd = 2'b11;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (stall_n !== 1'b1 || force_csb !== 2'b00 || init_done !== 1'b1) begin
                n_fail++;
                $display("FAIL zero_lat_c%0d: got stall_n=%b force_csb=%b init=%b expected 1 00 1",
                         c, stall_n, force_csb, init_done);
            end
        end
        req_rd = 2'b00;
    endtask

    task automatic test_reset_mid_wait();
        int edges;
        lat_cfg = {3'd0, 3'd5};
        @(negedge clk);
        req_rd = 2'b01;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (stall_n !== 1'b0 || force_csb !== 2'b01) begin
            n_fail++;
            $display("FAIL midwait_pre: got stall_n=%b force_csb=%b expected 0 01", stall_n, force_csb);
        end
        rstn   = 1'b0;
        req_rd = 2'b00;
        @(negedge clk);
        rstn = 1'b1;
        n_checks++;
        if (test_cs !== 2'b01 || test_we !== 1'b1 || test_en !== 1'b1 || init_done !== 1'b0 ||
            force_csb !== 2'b00 || stall_n !== 1'b0) begin
            n_fail++;
            $display("FAIL midwait_reset: got cs=%b we=%b en=%b init=%b force=%b stall_n=%b",
                     test_cs, test_we, test_en, init_done, force_csb, stall_n);
        end
        edges = 0;
        while (init_done !== 1'b1 && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        n_checks++;
        if (edges != 37) begin
            n_fail++;
            $display("FAIL midwait_rerun: got %0d expected 37", edges);
        end
    endtask

    initial begin
        test_reset();
        test_startup_pass();
        test_startup_fail();
        test_single_read();
        test_multi_read();
        test_back_to_back();
        test_zero_lat();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
